cmd_decoder: RTL and testbench
==============================

# cmd_decoder

Decode/dispatch stage directly downstream of the fetcher. Captures the three-word command window when the fetcher raises `exe_flag`, decodes the opcode, and hands ALU/stack work to the executor over a valid/ready handshake. It then returns `ready_flag`, `prev_cmd_size`, `jmp_flag` and `new_exe_addr_offset` to the fetcher to advance or redirect `ip`. Stops permanently on HLT or an illegal opcode until reset.

## Interface
- `address_size`, 32, width of `new_exe_addr_offset`
- `word_size`, 32, command word width; window = 3 words
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_arguments`  in  3*word_size  fetcher window; word0 = [word_size-1:0], word1 next, word2 top
- `exe_flag`  in  1  fetcher: window valid
- `ready_flag`  out  1  one-cycle pulse: fetcher updates `ip`
- `prev_cmd_size`  out  2  size of retired command in words (1..3)
- `jmp_flag`  out  1  redirect: fetcher adds `new_exe_addr_offset` instead of size
- `new_exe_addr_offset`  out  address_size  signed relative jump offset (word1)
- `dec_valid`  out  1  command presented to executor
- `dec_ready`  in  1  executor accepts
- `dec_opcode`  out  8  word0[7:0]
- `dec_operand0`, `dec_operand1`  out  word_size each  word1, word2
- `exe_done`  in  1  executor finished accepted command
- `exe_zero`  in  1  executor zero flag, sampled with `exe_done`
- `halted`  out  1  sticky, HLT retired
- `illegal`  out  1  sticky, unknown opcode captured

## Operation
- Opcodes (word0[7:0]) / size: NOP 0x00/1, PUSH 0x01/2, POP 0x02/1, ADD 0x03/1, SUB 0x04/1, MUL 0x05/1, MOV 0x06/3, JMP 0x10/2, JZ 0x11/2, JNZ 0x12/2, HLT 0xFF/1; all others illegal.
- States: WAIT, DISPATCH, EXEC, ISSUE, HALT, ERR.
- WAIT: on `exe_flag`=1 and `ready_flag`=0 capture window into registers; NOP/JMP -> ISSUE; HLT -> HALT; illegal -> ERR; else -> DISPATCH.
- DISPATCH: `dec_valid`=1, opcode/operands held stable; on `dec_ready`=1 -> EXEC.
- EXEC: wait `exe_done`; on it sample `exe_zero`, -> ISSUE. `exe_done` ignored in other states.
- ISSUE: `ready_flag`=1 exactly one cycle, -> WAIT.
- Jump resolution: JMP taken always; JZ taken iff sampled `exe_zero`=1; JNZ iff 0. Taken: `jmp_flag`=1, offset=word1 (truncated/sign-kept to address_size). Not taken / non-jump: `jmp_flag`=0, offset=0, `prev_cmd_size`=table size.
- HALT/ERR: terminal; no `ready_flag`, no `dec_valid`; `halted`/`illegal` held 1.

## Timing
- Reset (async, any state): state WAIT; `ready_flag`, `jmp_flag`, `dec_valid`, `halted`, `illegal` = 0; `prev_cmd_size`, `new_exe_addr_offset`, `dec_opcode`, operands = 0. Executor transaction in flight is abandoned. Fetcher `ip` is not reset by this block.
- `prev_cmd_size`, `jmp_flag`, `new_exe_addr_offset` registered, valid during the `ready_flag` cycle and held until next ISSUE.
- Fetcher clears `exe_flag` on the edge ending the `ready_flag` pulse; WAIT never recaptures a stale window (requires `exe_flag` sampled after pulse).
- Latency capture->`ready_flag`: NOP/JMP 1 cycle; ALU ops 2 + `dec_ready` wait + `exe_done` wait (min 3).
- `dec_valid` may not drop before `dec_ready`; `dec_ready` and `exe_done` in the same cycle: only the handshake counts.
- Offset 0 with JMP: legal, `jmp_flag`=1 (self-loop).

## Structure
- Package `cmd_decoder_pkg`: opcode localparams, size lookup function, state encoding, window-slice helpers.
- One combinational sub-module `opcode_lut`: opcode -> {size, is_jump, cond, is_halt, needs_exe, illegal}. FSM and registers in `cmd_decoder`.

## Test plan
- Reset then window {NOP} with `exe_flag`=1 -> next cycle `ready_flag`=1, size 1, `jmp_flag`=0, `dec_valid` never 1.
- PUSH 0x2A, `dec_ready` delayed 3 cycles, `exe_done` 2 later -> operand0=0x2A stable throughout, then one pulse with size 2.
- JZ offset 0xFFFFFFFC with `exe_zero`=1 -> `jmp_flag`=1, offset 0xFFFFFFFC; repeat with `exe_zero`=0 -> `jmp_flag`=0, size 2.
- MOV 5,7 -> operand0=5, operand1=7, size 3; opcode 0x7E -> `illegal`=1, no further `ready_flag`.
- HLT -> `halted`=1, outputs frozen for 50 cycles; assert `rst_n`=0 mid-EXEC of ADD -> all outputs 0 immediately, WAIT, resumes on next `exe_flag`.

Source files
------------

// File: rtl/cmd_decoder_pkg.sv
// Shared opcode map, FSM state encoding and command-window helpers for the
// command decoder.
package cmd_decoder_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_PUSH = 8'h01;
   localparam logic [7:0] OP_POP  = 8'h02;
   localparam logic [7:0] OP_ADD  = 8'h03;
   localparam logic [7:0] OP_SUB  = 8'h04;
   localparam logic [7:0] OP_MUL  = 8'h05;
   localparam logic [7:0] OP_MOV  = 8'h06;
   localparam logic [7:0] OP_JMP  = 8'h10;
   localparam logic [7:0] OP_JZ   = 8'h11;
   localparam logic [7:0] OP_JNZ  = 8'h12;
   localparam logic [7:0] OP_HLT  = 8'hFF;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DISPATCH,
      ST_EXEC,
      ST_ISSUE,
      ST_HALT,
      ST_ERR
   } state_t;

   typedef enum logic [1:0] {
      COND_ALWAYS,
      COND_ZERO,
      COND_NZERO
   } cond_t;

   typedef struct packed {
      logic [1:0] size;
      logic       is_jump;
      cond_t      cond;
      logic       is_halt;
      logic       needs_exe;
      logic       illegal;
   } op_info_t;

   // Command length in words; unknown opcodes report 1 but never retire.
   function automatic logic [1:0] op_size(input logic [7:0] op);
      case (op)
         OP_PUSH, OP_JMP, OP_JZ, OP_JNZ: op_size = 2'd2;
         OP_MOV:                         op_size = 2'd3;
         default:                        op_size = 2'd1;
      endcase
   endfunction

   function automatic int word_lsb(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/opcode_lut.sv
// Combinational opcode classifier: size, jump kind, halt, executor need and
// legality for one opcode byte.
module opcode_lut
   import cmd_decoder_pkg::*;
(
   input  logic [7:0] opcode,
   output op_info_t   info
);

   always_comb begin
      info      = '0;
      info.size = op_size(opcode);
      info.cond = COND_ALWAYS;
      case (opcode)
         OP_NOP: ;
         OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_MOV: info.needs_exe = 1'b1;
         OP_JMP: info.is_jump = 1'b1;
         OP_JZ: begin
            info.is_jump   = 1'b1;
            info.cond      = COND_ZERO;
            info.needs_exe = 1'b1;
         end
         OP_JNZ: begin
            info.is_jump   = 1'b1;
            info.cond      = COND_NZERO;
            info.needs_exe = 1'b1;
         end
         OP_HLT:  info.is_halt = 1'b1;
         default: info.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cmd_decoder.sv
// Decode/dispatch stage between fetcher and executor: captures the command
// window, hands work to the executor, and tells the fetcher how to move ip.
//
// state    | meaning
// WAIT     | idle, capture window on exe_flag
// DISPATCH | dec_valid high, waiting for dec_ready
// EXEC     | executor busy, waiting for exe_done
// ISSUE    | one-cycle ready_flag to fetcher
// HALT     | HLT retired, terminal until reset
// ERR      | illegal opcode captured, terminal until reset
module cmd_decoder
   import cmd_decoder_pkg::*;
#(
   parameter int address_size = 32,
   parameter int word_size    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [3*word_size-1:0]   cmd_arguments,
   input  logic                     exe_flag,
   output logic                     ready_flag,
   output logic [1:0]               prev_cmd_size,
   output logic                     jmp_flag,
   output logic [address_size-1:0]  new_exe_addr_offset,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [7:0]               dec_opcode,
   output logic [word_size-1:0]     dec_operand0,
   output logic [word_size-1:0]     dec_operand1,
   input  logic                     exe_done,
   input  logic                     exe_zero,
   output logic                     halted,
   output logic                     illegal
);

   localparam int W0_LSB = word_lsb(0, word_size);
   localparam int W1_LSB = word_lsb(1, word_size);
   localparam int W2_LSB = word_lsb(2, word_size);

   state_t                   state, state_nxt;
   logic [7:0]               opcode_q;
   logic [word_size-1:0]     opnd0_q, opnd1_q;
   logic [1:0]               size_q;
   logic                     jmp_q;
   logic [address_size-1:0]  off_q;

   logic [7:0]               win_opcode;
   logic [word_size-1:0]     win_word1, win_word2;
   logic                     unused_w0_hi;
   logic                     capture;
   logic [7:0]               lut_opcode;
   op_info_t                 info;
   logic [word_size-1:0]     jmp_word;
   logic [address_size-1:0]  off_ext;
   logic                     taken;
   logic                     issue_load;

   assign win_opcode   = cmd_arguments[W0_LSB +: 8];
   assign win_word1    = cmd_arguments[W1_LSB +: word_size];
   assign win_word2    = cmd_arguments[W2_LSB +: word_size];
   assign unused_w0_hi = ^cmd_arguments[W0_LSB + word_size - 1 : W0_LSB + 8];

   assign capture = (state == ST_WAIT) && exe_flag && !ready_flag;

   // In WAIT the LUT classifies the incoming window; afterwards the held opcode.
   assign lut_opcode = (state == ST_WAIT) ? win_opcode : opcode_q;
   assign jmp_word   = (state == ST_WAIT) ? win_word1 : opnd0_q;

   opcode_lut u_opcode_lut (
      .opcode (lut_opcode),
      .info   (info)
   );

   assign off_ext = address_size'(signed'(jmp_word));

   always_comb begin
      taken = 1'b0;
      if (info.is_jump) begin
         case (info.cond)
            COND_ALWAYS: taken = 1'b1;
            COND_ZERO:   taken = exe_zero;
            COND_NZERO:  taken = !exe_zero;
            default:     taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_nxt  = state;
      issue_load = 1'b0;
      case (state)
         ST_WAIT: begin
            if (capture) begin
               if (info.illegal)        state_nxt = ST_ERR;
               else if (info.is_halt)   state_nxt = ST_HALT;
               else if (info.needs_exe) state_nxt = ST_DISPATCH;
               else begin
                  state_nxt  = ST_ISSUE;
                  issue_load = 1'b1;
               end
            end
         end
         ST_DISPATCH: if (dec_ready) state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (exe_done) begin
               state_nxt  = ST_ISSUE;
               issue_load = 1'b1;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_HALT:  state_nxt = ST_HALT;
         ST_ERR:   state_nxt = ST_ERR;
         default:  state_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_WAIT;
         opcode_q <= '0;
         opnd0_q  <= '0;
         opnd1_q  <= '0;
         size_q   <= '0;
         jmp_q    <= 1'b0;
         off_q    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            opcode_q <= win_opcode;
            opnd0_q  <= win_word1;
            opnd1_q  <= win_word2;
         end
         if (issue_load) begin
            size_q <= info.size;
            jmp_q  <= taken;
            off_q  <= taken ? off_ext : '0;
         end
      end
   end

   assign ready_flag          = (state == ST_ISSUE);
   assign dec_valid           = (state == ST_DISPATCH);
   assign halted              = (state == ST_HALT);
   assign illegal             = (state == ST_ERR);
   assign prev_cmd_size       = size_q;
   assign jmp_flag            = jmp_q;
   assign new_exe_addr_offset = off_q;
   assign dec_opcode          = opcode_q;
   assign dec_operand0        = opnd0_q;
   assign dec_operand1        = opnd1_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: each step drives inputs, advances one clock
// and checks outputs 1ns after the rising edge against hand-computed values.
module tb_cmd_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [95:0] cmd_arguments = '0;
   logic        exe_flag = 1'b0;
   logic        ready_flag;
   logic [1:0]  prev_cmd_size;
   logic        jmp_flag;
   logic [31:0] new_exe_addr_offset;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [7:0]  dec_opcode;
   logic [31:0] dec_operand0;
   logic [31:0] dec_operand1;
   logic        exe_done = 1'b0;
   logic        exe_zero = 1'b0;
   logic        halted;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmd_decoder #(.address_size(32), .word_size(32)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .cmd_arguments       (cmd_arguments),
      .exe_flag            (exe_flag),
      .ready_flag          (ready_flag),
      .prev_cmd_size       (prev_cmd_size),
      .jmp_flag            (jmp_flag),
      .new_exe_addr_offset (new_exe_addr_offset),
      .dec_valid           (dec_valid),
      .dec_ready           (dec_ready),
      .dec_opcode          (dec_opcode),
      .dec_operand0        (dec_operand0),
      .dec_operand1        (dec_operand1),
      .exe_done            (exe_done),
      .exe_zero            (exe_zero),
      .halted              (halted),
      .illegal             (illegal)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] win(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2);
      return {w2, w1, w0};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},   32'(ready_flag), 0);
      chk({tag, "_jmp"},     32'(jmp_flag), 0);
      chk({tag, "_valid"},   32'(dec_valid), 0);
      chk({tag, "_halted"},  32'(halted), 0);
      chk({tag, "_illegal"}, 32'(illegal), 0);
      chk({tag, "_size"},    32'(prev_cmd_size), 0);
      chk({tag, "_offset"},  new_exe_addr_offset, 0);
      chk({tag, "_opcode"},  32'(dec_opcode), 0);
      chk({tag, "_op0"},     dec_operand0, 0);
      chk({tag, "_op1"},     dec_operand1, 0);
   endtask

   // Executor-bound command: immediate handshake, then exe_done with the given zero flag.
   // Returns in the ISSUE cycle with exe_flag already dropped.
   task automatic exec_cmd(input logic [95:0] w, input logic zero);
      cmd_arguments = w;
      exe_flag      = 1'b1;
      dec_ready     = 1'b1;
      step();
      chk("exec_dispatch_valid", 32'(dec_valid), 1);
      step();
      dec_ready = 1'b0;
      exe_done  = 1'b1;
      exe_zero  = zero;
      step();
      exe_done = 1'b0;
      exe_flag = 1'b0;
   endtask

   logic seen_ready;

   initial begin
      // reset state
      step();
      step();
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // NOP: ready the cycle after capture, no executor traffic
      cmd_arguments = win(32'h00, 0, 0);
      exe_flag = 1'b1;
      step();
      chk("nop_ready", 32'(ready_flag), 1);
      chk("nop_size",  32'(prev_cmd_size), 1);
      chk("nop_jmp",   32'(jmp_flag), 0);
      chk("nop_valid", 32'(dec_valid), 0);
      exe_flag = 1'b0;
      step();
      chk("nop_pulse_end", 32'(ready_flag), 0);
      chk("nop_size_held", 32'(prev_cmd_size), 1);

      // PUSH 0x2A with dec_ready held off 3 cycles, exe_done 2 cycles later
      cmd_arguments = win(32'h01, 32'h2A, 0);
      exe_flag = 1'b1;
      step();
      cmd_arguments = win(32'h02, 32'h55, 32'h66);
      for (int i = 0; i < 3; i++) begin
         chk("push_wait_valid", 32'(dec_valid), 1);
         chk("push_wait_op0",   dec_operand0, 32'h2A);
         chk("push_wait_opc",   32'(dec_opcode), 32'h01);
         chk("push_wait_ready", 32'(ready_flag), 0);
         step();
      end
      chk("push_valid_before_hs", 32'(dec_valid), 1);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      chk("push_exec_valid", 32'(dec_valid), 0);
      chk("push_exec_op0",   dec_operand0, 32'h2A);
      chk("push_exec_ready", 32'(ready_flag), 0);
      step();
      chk("push_exec_ready2", 32'(ready_flag), 0);
      exe_done = 1'b1;
      step();
      exe_done = 1'b0;
      exe_flag = 1'b0;
      chk("push_ready",  32'(ready_flag), 1);
      chk("push_size",   32'(prev_cmd_size), 2);
      chk("push_jmp",    32'(jmp_flag), 0);
      chk("push_offset", new_exe_addr_offset, 0);
      step();
      chk("push_pulse_end", 32'(ready_flag), 0);

      // JZ taken / not taken, JNZ taken
      exec_cmd(win(32'h11, 32'hFFFF_FFFC, 0), 1'b1);
      chk("jz_t_ready",  32'(ready_flag), 1);
      chk("jz_t_jmp",    32'(jmp_flag), 1);
      chk("jz_t_offset", new_exe_addr_offset, 32'hFFFF_FFFC);
      step();
      exec_cmd(win(32'h11, 32'hFFFF_FFFC, 0), 1'b0);
      chk("jz_n_ready",  32'(ready_flag), 1);
      chk("jz_n_jmp",    32'(jmp_flag), 0);
      chk("jz_n_size",   32'(prev_cmd_size), 2);
      chk("jz_n_offset", new_exe_addr_offset, 0);
      step();
      exec_cmd(win(32'h12, 32'h0000_0008, 0), 1'b0);
      chk("jnz_t_jmp",    32'(jmp_flag), 1);
      chk("jnz_t_offset", new_exe_addr_offset, 32'h8);
      step();

      // JMP with offset 0: one-cycle latency, self-loop
      cmd_arguments = win(32'h10, 0, 0);
      exe_flag = 1'b1;
      step();
      chk("jmp0_ready",  32'(ready_flag), 1);
      chk("jmp0_jmp",    32'(jmp_flag), 1);
      chk("jmp0_offset", new_exe_addr_offset, 0);
      chk("jmp0_valid",  32'(dec_valid), 0);
      exe_flag = 1'b0;
      step();

      // ADD: exe_done coinciding with the handshake must be ignored
      cmd_arguments = win(32'h03, 0, 0);
      exe_flag = 1'b1;
      step();
      dec_ready = 1'b1;
      exe_done  = 1'b1;
      step();
      chk("add_hs_ready", 32'(ready_flag), 0);
      dec_ready = 1'b0;
      exe_done  = 1'b0;
      step();
      chk("add_exec_ready", 32'(ready_flag), 0);
      chk("add_exec_valid", 32'(dec_valid), 0);
      exe_done = 1'b1;
      step();
      exe_done = 1'b0;
      exe_flag = 1'b0;
      chk("add_ready",  32'(ready_flag), 1);
      chk("add_size",   32'(prev_cmd_size), 1);
      chk("add_jmp",    32'(jmp_flag), 0);
      chk("add_offset", new_exe_addr_offset, 0);
      step();

      // MOV 5,7
      cmd_arguments = win(32'h06, 32'h5, 32'h7);
      exe_flag = 1'b1;
      step();
      chk("mov_opc", 32'(dec_opcode), 32'h06);
      chk("mov_op0", dec_operand0, 32'h5);
      chk("mov_op1", dec_operand1, 32'h7);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      exe_done  = 1'b1;
      step();
      exe_done = 1'b0;
      exe_flag = 1'b0;
      chk("mov_ready", 32'(ready_flag), 1);
      chk("mov_size",  32'(prev_cmd_size), 3);
      step();

      // Illegal opcode: sticky, no further ready_flag
      cmd_arguments = win(32'h7E, 0, 0);
      exe_flag = 1'b1;
      step();
      chk("ill_flag",  32'(illegal), 1);
      chk("ill_valid", 32'(dec_valid), 0);
      chk("ill_ready", 32'(ready_flag), 0);
      cmd_arguments = win(32'h00, 0, 0);
      dec_ready = 1'b1;
      exe_done  = 1'b1;
      seen_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         seen_ready = seen_ready | ready_flag | dec_valid;
      end
      chk("ill_no_ready", 32'(seen_ready), 0);
      chk("ill_sticky",   32'(illegal), 1);
      rst_n = 1'b0;
      #1;
      chk("ill_reset_clears", 32'(illegal), 0);
      exe_flag  = 1'b0;
      dec_ready = 1'b0;
      exe_done  = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // HLT: frozen for 50 cycles despite activity on every input
      cmd_arguments = win(32'hFF, 0, 0);
      exe_flag = 1'b1;
      step();
      chk("hlt_halted", 32'(halted), 1);
      chk("hlt_ready",  32'(ready_flag), 0);
      cmd_arguments = win(32'h00, 0, 0);
      for (int i = 0; i < 50; i++) begin
         dec_ready = i[0];
         exe_done  = i[1];
         exe_zero  = i[2];
         step();
         chk("hlt_frz_halted", 32'(halted), 1);
         chk("hlt_frz_ready",  32'(ready_flag), 0);
         chk("hlt_frz_valid",  32'(dec_valid), 0);
         chk("hlt_frz_size",   32'(prev_cmd_size), 0);
         chk("hlt_frz_jmp",    32'(jmp_flag), 0);
      end
      rst_n = 1'b0;
      exe_flag  = 1'b0;
      dec_ready = 1'b0;
      exe_done  = 1'b0;
      exe_zero  = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("hlt_reset_clears", 32'(halted), 0);

      // Reset mid-EXEC of ADD, then resume
      cmd_arguments = win(32'h00, 0, 0);
      exe_flag = 1'b1;
      step();
      exe_flag = 1'b0;
      step();
      chk("pre_add_size", 32'(prev_cmd_size), 1);
      cmd_arguments = win(32'h03, 32'h11, 32'h22);
      exe_flag  = 1'b1;
      dec_ready = 1'b1;
      step();
      step();
      dec_ready = 1'b0;
      chk("mid_exec_opc",   32'(dec_opcode), 32'h03);
      chk("mid_exec_valid", 32'(dec_valid), 0);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_exec");
      exe_flag = 1'b0;
      exe_done = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(ready_flag), 0);
      chk("post_rst_valid", 32'(dec_valid), 0);
      exe_done = 1'b0;
      cmd_arguments = win(32'h00, 0, 0);
      exe_flag = 1'b1;
      step();
      chk("resume_ready", 32'(ready_flag), 1);
      chk("resume_size",  32'(prev_cmd_size), 1);
      exe_flag = 1'b0;
      step();
      chk("resume_end", 32'(ready_flag), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
